// File: rtl/md_pkg.sv
// Shared encodings, default latencies and helpers for the multiply/divide scheduler.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    StIdle,
    StBusy
  } md_state_e;

  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  function automatic logic is_md_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational MULT/MULTU/DIV/DIVU datapath producing the HI/LO pair for one operation.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic        signed_op;
  logic        rs_neg;
  logic        rt_neg;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] divisor;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [63:0] prod_mag;
  logic [63:0] prod;

  // Signed ops run on magnitudes; -2^31 / -1 then wraps naturally to 8000_0000 rem 0.
  always_comb begin
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    rs_neg    = signed_op & rs_val[31];
    rt_neg    = signed_op & rt_val[31];
    rs_mag    = rs_neg ? (32'd0 - rs_val) : rs_val;
    rt_mag    = rt_neg ? (32'd0 - rt_val) : rt_val;

    prod_mag  = {32'd0, rs_mag} * {32'd0, rt_mag};
    prod      = (rs_neg ^ rt_neg) ? (64'd0 - prod_mag) : prod_mag;

    div_zero  = is_md_div(op) && (rt_val == 32'd0);
    divisor   = (rt_val == 32'd0) ? 32'd1 : rt_mag;
    quo_mag   = rs_mag / divisor;
    rem_mag   = rs_mag % divisor;

    res_hi = 32'd0;
    res_lo = 32'd0;
    if (is_md_div(op)) begin
      res_lo = (rs_neg ^ rt_neg) ? (32'd0 - quo_mag) : quo_mag;
      res_hi = rs_neg ? (32'd0 - rem_mag) : rem_mag;
    end else if (is_md_arith(op)) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

endmodule

// File: rtl/md_sched.sv
// HI/LO owner for the MIPS pipeline: sequences multi-cycle mul/div, MTHI/MTLO and the D-stage stall.
module md_sched
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

  md_state_e       state;
  logic [CntW-1:0] count;
  logic [31:0]     pend_hi;
  logic [31:0]     pend_lo;
  logic            pend_zero;

  logic [31:0]     res_hi;
  logic [31:0]     res_lo;
  logic            div_zero;

  md_calc u_calc (
    .op       (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      busy      <= 1'b0;
      count     <= '0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_zero <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            if (is_md_arith(md_op)) begin
              pend_hi   <= res_hi;
              pend_lo   <= res_lo;
              pend_zero <= div_zero;
              count     <= is_md_div(md_op) ? DivLoad : MultLoad;
              busy      <= 1'b1;
              state     <= StBusy;
            end else if (md_op == MD_MTHI) begin
              hi <= rs_val;
            end else if (md_op == MD_MTLO) begin
              lo <= rs_val;
            end
          end
        end
        StBusy: begin
          if (count == '0) begin
            // Divide by zero still occupies the unit but leaves HI/LO untouched.
            if (!pend_zero) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            busy  <= 1'b0;
            state <= StIdle;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

  // Held through the final busy cycle so MFHI/MFLO reach E only after the commit edge.
  assign md_stall = d_uses_md & (busy | (start & is_md_arith(md_op)));

  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (reset) !(start && busy && (md_op != MD_NOP))
  );

endmodule

// File: tb/tb_md_sched.sv
// Randomized scoreboard bench for md_sched with a longint arithmetic reference model.
module tb_md_sched;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_uses_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  md_sched #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .d_uses_md (d_uses_md),
    .busy      (busy),
    .md_stall  (md_stall),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        scb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: architectural HI/LO after the op, and how long the unit stays busy.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int len);
    longint          sa;
    longint          sb;
    longint          q;
    longint          r;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned uq;
    longint unsigned ur;
    logic [63:0]     p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    len = 0;
    case (op)
      3'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; len = 5; end
      3'd2: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; len = 5; end
      3'd3: begin
        len = 10;
        if (b != 32'd0) begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
      3'd4: begin
        len = 10;
        if (b != 32'd0) begin
          uq = ua / ub; ur = ua % ub;
          m_lo = uq[31:0]; m_hi = ur[31:0];
        end
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit track);
    int len;
    if (track) begin
      model(op, a, b, len);
      if (op >= 3'd1 && op <= 3'd6) scb.push_back('{len, m_hi, m_lo});
    end
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    @(posedge clk); #1;
    start  = 1'b0;
    md_op  = 3'd0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: busy got 1, expected 0", nm);
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: an output event is a busy fall (commit) or the edge after an idle MTHI/MTLO.
  int   run_len   = 0;
  logic prev_busy = 1'b0;
  logic prev_mt   = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      run_len   = 0;
      prev_busy = 1'b0;
      prev_mt   = 1'b0;
    end else begin
      if (prev_mt || (prev_busy && !busy)) begin
        if (scb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: output event got with empty queue, expected none");
        end else begin
          e = scb.pop_front();
          chk("sb_busy_len", 32'(run_len), 32'(e.len));
          chk("sb_hi", hi, e.hi);
          chk("sb_lo", lo, e.lo);
        end
        run_len = 0;
      end
      if (busy) run_len++;
      prev_busy = busy;
      prev_mt   = start && !busy && (md_op == MD_MTHI || md_op == MD_MTLO);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    md_op     = 3'd0;
    rs_val    = 32'd0;
    rt_val    = 32'd0;
    d_uses_md = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_stall", md_stall, 0);

    // Reset while a MULT is in flight discards the pending result.
    issue(3'd5, 32'd99, 32'd0, 1'b1);
    issue(3'd1, 32'd3, 32'd4, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    chk("midop_busy", busy, 0);
    chk("midop_hi", hi, 0);
    chk("midop_lo", lo, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("midop_no_commit_hi", hi, 0);
    chk("midop_no_commit_lo", lo, 0);

    // MULT -2*3 with MFLO waiting in D.
    d_uses_md = 1'b1;
    begin
      int len;
      model(3'd1, 32'hFFFF_FFFE, 32'd3, len);
      scb.push_back('{len, m_hi, m_lo});
    end
    start = 1'b1; md_op = 3'd1; rs_val = 32'hFFFF_FFFE; rt_val = 32'd3;
    @(negedge clk);
    chk("stall_issue", md_stall, 1);
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_busy", md_stall, 1);
    end
    @(negedge clk);
    chk("stall_release", md_stall, 0);
    chk("mflo_new_lo", lo, 32'hFFFF_FFFA);
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    d_uses_md = 1'b0;
    @(posedge clk); #1;

    // DIVU with a non-md instruction in D never stalls.
    issue(3'd4, 32'd7, 32'd2, 1'b1);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk("nonmd_stall", md_stall, 0);
    end
    @(posedge clk); #1;
    wait_idle("divu");
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_idle("div_neg");
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    issue(3'd5, 32'd11, 32'd0, 1'b1);
    issue(3'd6, 32'd22, 32'd0, 1'b1);
    issue(3'd3, 32'd1234, 32'd0, 1'b1);
    wait_idle("div_zero");
    chk("div_zero_hi", hi, 32'd11);
    chk("div_zero_lo", lo, 32'd22);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle("div_ovf");
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'd0);

    issue(3'd5, 32'd5, 32'd0, 1'b1);
    chk("mthi_no_busy", busy, 0);
    issue(3'd6, 32'd6, 32'd0, 1'b1);
    chk("mtlo_no_busy", busy, 0);
    chk("mt_hi", hi, 32'd5);
    chk("mt_lo", lo, 32'd6);

    for (int n = 0; n < 80; n++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(0, 6));
      a  = rnd_val();
      b  = rnd_val();
      issue(op, a, b, 1'b1);
      wait_idle("rand");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(scb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
